// File: rtl/timer_arbiter.sv
// Round-robin arbiter that lends one shared down-counter to one requester at a time.
// Each granted requester holds req for its interval; dropping req aborts without a done pulse.
module timer_arbiter #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*WIDTH-1:0] len,
    output logic [NREQ-1:0]       grant,
    output logic                  busy,
    output logic [WIDTH-1:0]      count,
    output logic [NREQ-1:0]       done
);

    localparam int unsigned N  = NREQ;
    localparam int          IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;

    state_t          state;
    logic [IW-1:0]   last;
    logic [IW-1:0]   winner;
    logic [IW-1:0]   pick;
    logic [IW-1:0]   cand;
    logic            found;
    logic [WIDTH-1:0] len_arr [NREQ];

    function automatic logic [NREQ-1:0] onehot(input logic [IW-1:0] i);
        onehot    = '0;
        onehot[i] = 1'b1;
    endfunction

    always_comb begin
        for (int unsigned i = 0; i < N; i++) begin
            len_arr[i] = len[i*WIDTH +: WIDTH];
        end
    end

    // Scan starts one past the last grant and wraps, so the first hit is the fairest.
    always_comb begin
        pick  = '0;
        cand  = '0;
        found = 1'b0;
        for (int unsigned off = 0; off < N; off++) begin
            cand = IW'((32'(last) + 32'd1 + off) % N);
            if (!found && req[cand]) begin
                pick  = cand;
                found = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            grant  <= '0;
            done   <= '0;
            busy   <= 1'b0;
            count  <= '0;
            last   <= IW'(NREQ - 1);
            winner <= '0;
        end else begin
            done <= '0;
            case (state)
                IDLE: begin
                    if (found) begin
                        state  <= LOAD;
                        grant  <= onehot(pick);
                        winner <= pick;
                        last   <= pick;
                        busy   <= 1'b1;
                    end
                end
                LOAD: begin
                    count <= len_arr[winner];
                    state <= RUN;
                end
                RUN: begin
                    // Abort is tested first so it beats a same-cycle completion.
                    if (!req[winner]) begin
                        state <= IDLE;
                        grant <= '0;
                        count <= '0;
                        busy  <= 1'b0;
                    end else if (count != '0) begin
                        count <= count - 1'b1;
                    end else begin
                        state <= DONE;
                        grant <= '0;
                        done  <= onehot(winner);
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    grant <= '0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_timer_arbiter.sv
// Directed bench for timer_arbiter: grant/done events are checked against a scoreboard
// queue by a negedge monitor, cycle-level count/busy values are checked inline.
module tb_timer_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  req;
    logic [31:0] len;
    logic [3:0]  grant;
    logic        busy;
    logic [7:0]  count;
    logic [3:0]  done;

    int checks = 0;
    int errors = 0;

    logic [3:0] exp_grant [$];
    logic [3:0] exp_done  [$];
    logic [3:0] prev_grant;
    logic [3:0] mon_exp;
    logic       mon_en = 1'b0;

    timer_arbiter #(.NREQ(4), .WIDTH(8)) dut (
        .clk   (clk),
        .reset (reset),
        .req   (req),
        .len   (len),
        .grant (grant),
        .busy  (busy),
        .count (count),
        .done  (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_len(input int i, input logic [7:0] v);
        len[i*8 +: 8] = v;
    endtask

    // Scoreboard monitor: every new grant and every done pulse must match the next queued entry.
    always @(negedge clk) begin
        if (mon_en && !reset) begin
            if (grant !== 4'b0 && prev_grant === 4'b0) begin
                if (exp_grant.size() == 0) begin
                    chk("unexpected_grant", {28'b0, grant}, 32'h0);
                end else begin
                    mon_exp = exp_grant.pop_front();
                    chk("grant_order", {28'b0, grant}, {28'b0, mon_exp});
                end
            end
            if (done !== 4'b0) begin
                chk("done_onehot", {31'b0, $onehot(done)}, 32'h1);
                if (exp_done.size() == 0) begin
                    chk("unexpected_done", {28'b0, done}, 32'h0);
                end else begin
                    mon_exp = exp_done.pop_front();
                    chk("done_pulse", {28'b0, done}, {28'b0, mon_exp});
                end
            end
        end
        prev_grant = grant;
    end

    initial begin
        reset = 1'b1;
        req   = 4'b0;
        len   = '0;
        tick();
        tick();
        chk("rst_grant", {28'b0, grant}, 32'h0);
        chk("rst_busy",  {31'b0, busy},  32'h0);
        chk("rst_count", {24'b0, count}, 32'h0);
        chk("rst_done",  {28'b0, done},  32'h0);
        reset  = 1'b0;
        mon_en = 1'b1;
        tick();
        chk("idle_no_req_busy", {31'b0, busy}, 32'h0);

        // Single requester 0, len 3
        set_len(0, 8'd3);
        req = 4'b0001;
        exp_grant.push_back(4'b0001);
        exp_done.push_back(4'b0001);
        tick();
        chk("t1_load_grant", {28'b0, grant}, 32'h1);
        chk("t1_load_busy",  {31'b0, busy},  32'h1);
        for (int k = 3; k >= 0; k--) begin
            tick();
            chk("t1_run_count", {24'b0, count}, k);
            chk("t1_run_grant", {28'b0, grant}, 32'h1);
        end
        tick();
        chk("t1_done_grant", {28'b0, grant}, 32'h0);
        chk("t1_done_busy",  {31'b0, busy},  32'h1);
        req = 4'b0;
        tick();
        chk("t1_idle_busy", {31'b0, busy}, 32'h0);
        chk("t1_idle_done", {28'b0, done}, 32'h0);

        // All requesting with zero length: round-robin wraps back to 0
        set_len(0, 8'd0);
        req = 4'b1111;
        exp_grant.push_back(4'b0010); exp_done.push_back(4'b0010);
        exp_grant.push_back(4'b0100); exp_done.push_back(4'b0100);
        exp_grant.push_back(4'b1000); exp_done.push_back(4'b1000);
        exp_grant.push_back(4'b0001); exp_done.push_back(4'b0001);
        for (int n = 0; n < 4; n++) begin
            tick();
            chk("t2_load_busy", {31'b0, busy}, 32'h1);
            tick();
            chk("t2_run_count", {24'b0, count}, 32'h0);
            tick();
            chk("t2_done_grant", {28'b0, grant}, 32'h0);
            tick();
            chk("t2_gap_busy", {31'b0, busy}, 32'h0);
        end
        req = 4'b0;

        // Abort requester 2 at count 2
        set_len(2, 8'd5);
        set_len(3, 8'd4);
        req = 4'b0100;
        exp_grant.push_back(4'b0100);
        tick();
        for (int k = 5; k >= 2; k--) begin
            tick();
            chk("t3_run_count", {24'b0, count}, k);
        end
        req = 4'b0;
        tick();
        chk("t3_abort_busy",  {31'b0, busy},  32'h0);
        chk("t3_abort_grant", {28'b0, grant}, 32'h0);
        chk("t3_abort_count", {24'b0, count}, 32'h0);
        chk("t3_abort_done",  {28'b0, done},  32'h0);

        // After abort of 2, scan begins at 3 even though 0 is requesting
        req = 4'b1001;
        exp_grant.push_back(4'b1000);
        tick();
        chk("t4_grant3", {28'b0, grant}, 32'h8);
        tick();
        chk("t4_run_count", {24'b0, count}, 32'h4);
        reset = 1'b1;
        tick();
        chk("t4_rst_grant", {28'b0, grant}, 32'h0);
        chk("t4_rst_busy",  {31'b0, busy},  32'h0);
        chk("t4_rst_count", {24'b0, count}, 32'h0);
        chk("t4_rst_done",  {28'b0, done},  32'h0);
        reset = 1'b0;

        // After reset requester 1 beats 3; then a full-range 256-cycle run
        set_len(1, 8'hFF);
        req = 4'b1010;
        exp_grant.push_back(4'b0010);
        exp_done.push_back(4'b0010);
        tick();
        chk("t5_grant1", {28'b0, grant}, 32'h2);
        req = 4'b0010;
        tick();
        chk("t5_run_start", {24'b0, count}, 32'hFF);
        for (int k = 254; k >= 0; k--) begin
            tick();
            chk("t5_run_count", {24'b0, count}, k);
        end
        tick();
        chk("t5_no_underflow", {24'b0, count}, 32'h0);
        chk("t5_done_busy",    {31'b0, busy},  32'h1);
        req = 4'b0;
        tick();
        chk("t5_idle_busy", {31'b0, busy}, 32'h0);

        // last=1: requester 2 before 1, with an IDLE gap between
        set_len(1, 8'd1);
        set_len(2, 8'd2);
        req = 4'b0110;
        exp_grant.push_back(4'b0100); exp_done.push_back(4'b0100);
        exp_grant.push_back(4'b0010); exp_done.push_back(4'b0010);
        tick();
        chk("t6_first_grant", {28'b0, grant}, 32'h4);
        for (int k = 2; k >= 0; k--) begin
            tick();
            chk("t6_run2_count", {24'b0, count}, k);
        end
        tick();
        tick();
        chk("t6_gap_grant", {28'b0, grant}, 32'h0);
        chk("t6_gap_busy",  {31'b0, busy},  32'h0);
        tick();
        chk("t6_second_grant", {28'b0, grant}, 32'h2);
        for (int k = 1; k >= 0; k--) begin
            tick();
            chk("t6_run1_count", {24'b0, count}, k);
        end
        tick();
        req = 4'b0;
        tick();
        tick();
        tick();
        chk("t6_final_busy", {31'b0, busy}, 32'h0);
        chk("sb_grant_drained", exp_grant.size(), 32'h0);
        chk("sb_done_drained",  exp_done.size(),  32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/timer_arbiter.md
TIMER_ARBITER -- requirements
Module: timer_arbiter

Interface
REQ-001 Parameter NREQ, default 4, number of requesters sharing the interval counter; legal range 2..8.
REQ-002 Parameter WIDTH, default 8, width of the interval counter and of each length field.
REQ-003 clk  input  1  clock; all state updates on rising edge.
REQ-004 reset  input  1  reset, synchronous, active-high.
REQ-005 req  input  NREQ  per-requester request level; req[i] held high for the whole wanted interval.
REQ-006 len  input  NREQ*WIDTH  packed interval lengths; len[i*WIDTH +: WIDTH] belongs to requester i and is sampled only in LOAD.
REQ-007 grant  output  NREQ  registered one-hot grant, or all-zero when no requester is granted.
REQ-008 busy  output  1  registered; high whenever the state is not IDLE.
REQ-009 count  output  WIDTH  registered remaining-count value of the shared counter.
REQ-010 done  output  NREQ  registered one-cycle completion pulse for requester i; at most one bit high per cycle.

Function
REQ-011 The block SHALL implement exactly four states: IDLE, LOAD, RUN and DONE.
REQ-012 In IDLE with req all-zero, the block SHALL stay in IDLE with grant=0 and count unchanged.
REQ-013 In IDLE with any req bit high, the block SHALL select a winner by round-robin, scanning from index (last+1) mod NREQ upward with wrap, where last is the most recently granted index.
REQ-014 On selection, the next state SHALL be LOAD and grant SHALL be the one-hot winner, visible the cycle after req is sampled (1-cycle grant latency).
REQ-015 In LOAD (one cycle), the block SHALL set count <= len[winner] and move to RUN.
REQ-016 In RUN with count != 0 and req[winner] high, the block SHALL set count <= count-1.
REQ-017 RUN SHALL therefore last len+1 cycles (count = len, len-1, ..., 0), so len=0 yields exactly one RUN cycle.
REQ-018 In RUN with count == 0 and req[winner] high, the next state SHALL be DONE.
REQ-019 In DONE (one cycle), the block SHALL hold done[winner]=1 and grant=0, then move to IDLE.
REQ-020 In RUN, if req[winner] is low, the block SHALL abort: next state IDLE, grant=0, count<=0, no done pulse.
REQ-021 An abort SHALL take priority over the count==0 completion when both occur in the same cycle.
REQ-022 The block SHALL update last to the winner on LOAD entry, so it advances on both completed and aborted intervals.
REQ-023 The block SHALL ignore req bits of non-granted requesters during LOAD, RUN and DONE; those requesters wait with no loss.
REQ-024 A new arbitration SHALL occur only from IDLE, so back-to-back intervals have a 1-cycle IDLE gap after DONE.
REQ-025 The block SHALL never decrement count below 0 (no wrap); WIDTH arithmetic SHALL be unsigned.
REQ-026 grant SHALL be high from the LOAD cycle through the last RUN cycle inclusive.
REQ-027 busy SHALL be high in LOAD, RUN and DONE.

Reset
REQ-028 While reset=1 at a clock edge, the block SHALL set state=IDLE, grant=0, done=0, busy=0, count=0 and last=NREQ-1, so requester 0 has top priority after reset.
REQ-029 Reset SHALL override every other input, including reset asserted mid-RUN, which SHALL produce no done pulse.

Verification
REQ-030 Reset, then req=4'b0001, len0=3 -> grant=0001 at cycle 1; count 3,2,1,0 in RUN; done[0] pulse 6 cycles after req; busy low next cycle.
REQ-031 req=4'b1111 held continuously, all len=0 -> grants in order 0001,0010,0100,1000,0001, each followed by its done pulse; round-robin wraps.
REQ-032 Requester 2 granted, len2=5; drop req[2] when count=2 -> next cycle IDLE, grant=0, count=0, no done[2]; the next arbitration starts at index 3.
REQ-033 len1=8'hFF, req[1] only -> 256 RUN cycles, no underflow, single done[1] pulse.
REQ-034 Assert reset during RUN with count=4 -> next cycle all outputs zero; req=4'b1010 then grants requester 1 first.
REQ-035 req=4'b0110 with last=1 -> requester 2 granted before 1; requester 1 is granted after DONE plus the 1-cycle IDLE gap.
